// File: rtl/mem_store_buffer_pkg.sv
// Shared types for the MEM-stage store buffer: memory control word, FSM states, entry layout.
package mem_store_buffer_pkg;

   typedef struct packed {
      logic       memRead;
      logic       memWrite;
      logic [1:0] size;     // 0 = byte, 1 = half, 2 = word
      logic       sign;
   } mem_ctrl_t;

   typedef enum logic {
      RUN   = 1'b0,
      FENCE = 1'b1
   } sb_state_t;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [1:0]  size;
   } sb_entry_t;

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   // Keep only the low bytes a store of this size actually writes
   function automatic logic [31:0] size_mask(input logic [1:0] size);
      case (size)
         SZ_B:    return 32'h0000_00FF;
         SZ_H:    return 32'h0000_FFFF;
         default: return 32'hFFFF_FFFF;
      endcase
   endfunction

endpackage

// File: rtl/mem_sb_cam.sv
// Store-buffer entry array with per-entry valid bits and word-address match against a load.
module mem_sb_cam
   import mem_store_buffer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset_n,
   input  logic             i_push,
   input  logic [PW-1:0]    i_push_idx,
   input  sb_entry_t        i_push_entry,
   input  logic             i_pop,
   input  logic [PW-1:0]    i_pop_idx,
   output sb_entry_t        o_head_entry,
   input  logic [31:0]      i_lookup_addr,
   output logic [DEPTH-1:0] o_conflict
);

   sb_entry_t        entries [DEPTH];
   logic [DEPTH-1:0] valid;

   // Valid bits: clear on pop, set on push; push wins when full and both hit the same slot
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         valid <= '0;
      end else begin
         if (i_pop)  valid[i_pop_idx]  <= 1'b0;
         if (i_push) valid[i_push_idx] <= 1'b1;
      end
   end

   // Payload needs no reset: every use is qualified by its valid bit
   always_ff @(posedge i_clk) begin
      if (i_push) entries[i_push_idx] <= i_push_entry;
   end

   assign o_head_entry = entries[i_pop_idx];

   // Flag every live entry whose word address matches the load
   always_comb begin
      o_conflict = '0;
      for (int i = 0; i < DEPTH; i++)
         o_conflict[i] = valid[i] && (entries[i].addr[31:2] == i_lookup_addr[31:2]);
   end

endmodule

// File: rtl/mem_store_buffer.sv
// MEM-stage store buffer: queues stores, drains them in order when the port is free,
// lets non-conflicting loads bypass, and drains fully on a fence.
module mem_store_buffer
   import mem_store_buffer_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = $clog2(DEPTH) + 1
) (
   input  logic          i_clk,
   input  logic          i_reset_n,
   input  logic          i_valid,
   input  logic [31:0]   i_memAddr,
   input  logic [31:0]   i_writeData,
   input  mem_ctrl_t     i_ctrlMEM,
   input  logic          i_memBusy,
   input  logic          i_fence,
   output logic [31:0]   o_memAddr,
   output logic [31:0]   o_writeData,
   output mem_ctrl_t     o_ctrlMEM,
   output logic          o_stall,
   output logic [CW-1:0] o_count
);

   sb_state_t        state, state_next;
   logic [PW-1:0]    head, tail;
   logic [CW-1:0]    count, count_next;
   logic             is_load, is_store, conflict, full;
   logic             fence_block, load_issue, drain, push;
   logic [DEPTH-1:0] conflict_vec;
   sb_entry_t        head_entry, push_entry;

   assign is_load  = i_valid & i_ctrlMEM.memRead;
   assign is_store = i_valid & i_ctrlMEM.memWrite;
   assign conflict = |conflict_vec;
   assign full     = (count == CW'(DEPTH));
   assign o_count  = count;

   assign push_entry.addr = i_memAddr;
   assign push_entry.data = i_writeData & size_mask(i_ctrlMEM.size);
   assign push_entry.size = i_ctrlMEM.size;

   mem_sb_cam #(.DEPTH(DEPTH)) u_cam (
      .i_clk         (i_clk),
      .i_reset_n     (i_reset_n),
      .i_push        (push),
      .i_push_idx    (tail),
      .i_push_entry  (push_entry),
      .i_pop         (drain),
      .i_pop_idx     (head),
      .o_head_entry  (head_entry),
      .i_lookup_addr (i_memAddr),
      .o_conflict    (conflict_vec)
   );

   // Control: a fence blocks new accesses from the cycle it is seen until the buffer empties
   always_comb begin
      fence_block = (state == FENCE) || (i_fence && count != '0);
      load_issue  = is_load && !conflict && !fence_block;
      drain       = (count != '0) && !load_issue && !i_memBusy;
      o_stall     = fence_block || (is_load && conflict) || (is_store && full && !drain);
      push        = is_store && !o_stall;
      count_next  = count + CW'(push) - CW'(drain);
      state_next  = (fence_block && count_next != '0) ? FENCE : RUN;
   end

   // Memory port mux: bypassing load first, then head-of-queue drain, else idle
   always_comb begin
      o_memAddr   = '0;
      o_writeData = '0;
      o_ctrlMEM   = '0;
      if (load_issue) begin
         o_memAddr          = i_memAddr;
         o_ctrlMEM          = i_ctrlMEM;
         o_ctrlMEM.memWrite = 1'b0;
      end else if (drain) begin
         o_memAddr          = head_entry.addr;
         o_writeData        = head_entry.data;
         o_ctrlMEM.memWrite = 1'b1;
         o_ctrlMEM.size     = head_entry.size;
      end
   end

   // State, pointers and occupancy; pointers wrap naturally since DEPTH is a power of two
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state <= RUN;
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
         if (drain) head <= head + PW'(1);
         if (push)  tail <= tail + PW'(1);
      end
   end

endmodule

// File: tb/tb_mem_store_buffer.sv
// Self-checking bench for mem_store_buffer: directed vector table, hand sequences, random vs queue model.
module tb_mem_store_buffer;
   import mem_store_buffer_pkg::*;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic          i_clk = 1'b0;
   logic          i_reset_n = 1'b0;
   logic          i_valid = 1'b0;
   logic [31:0]   i_memAddr = '0;
   logic [31:0]   i_writeData = '0;
   mem_ctrl_t     i_ctrlMEM = '0;
   logic          i_memBusy = 1'b0;
   logic          i_fence = 1'b0;
   logic [31:0]   o_memAddr, o_writeData;
   mem_ctrl_t     o_ctrlMEM;
   logic          o_stall;
   logic [CW-1:0] o_count;

   always #5 i_clk = ~i_clk;

   mem_store_buffer #(.DEPTH(DEPTH)) dut (
      .i_clk(i_clk), .i_reset_n(i_reset_n), .i_valid(i_valid), .i_memAddr(i_memAddr),
      .i_writeData(i_writeData), .i_ctrlMEM(i_ctrlMEM), .i_memBusy(i_memBusy), .i_fence(i_fence),
      .o_memAddr(o_memAddr), .o_writeData(o_writeData), .o_ctrlMEM(o_ctrlMEM),
      .o_stall(o_stall), .o_count(o_count)
   );

   int n_chk = 0;
   int n_fail = 0;

   typedef struct { bit ld; bit st; bit busy; bit fence; logic [31:0] addr; logic [31:0] data; logic [1:0] size; } op_t;
   typedef struct { op_t op; bit e_stall; bit e_we; logic [31:0] e_addr; int e_cnt; } vec_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; logic [1:0] size; } st_t;

   // Reference model: FIFO of pending stores plus a fence-pending flag
   st_t         sq[$];
   bit          m_fence = 1'b0;
   logic [31:0] ref_mem[int];
   logic [31:0] dut_mem[int];

   bit          l_stall, l_we;
   logic [31:0] l_addr, l_rdata;
   int          l_cnt;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic op_t mk(input bit ld, input bit st, input bit busy, input bit fence,
                              input logic [31:0] addr, input logic [31:0] data, input logic [1:0] size);
      op_t o;
      o.ld = ld; o.st = st; o.busy = busy; o.fence = fence;
      o.addr = addr; o.data = data; o.size = size;
      return o;
   endfunction

   function automatic logic [31:0] bmask(input logic [1:0] sz);
      if (sz == 2'd0) return 32'hFF;
      if (sz == 2'd1) return 32'hFFFF;
      return 32'hFFFF_FFFF;
   endfunction

   // Byte-lane write into a memory word
   function automatic logic [31:0] merge(input logic [31:0] w, input logic [31:0] a,
                                         input logic [31:0] d, input logic [1:0] sz);
      logic [31:0] r;
      int sh;
      r  = w;
      sh = 8 * int'(a[1:0]);
      if (sz == 2'd0)      r[sh +: 8]  = d[7:0];
      else if (sz == 2'd1) r[sh +: 16] = d[15:0];
      else                 r = d;
      return r;
   endfunction

   // Drive one cycle, compare against the model at negedge, advance the model
   task automatic step(input op_t op);
      int n; bit blocked, hit, ld_go, drn, e_stall;
      mem_ctrl_t e_ctrl; logic [31:0] e_addr, e_data;
      int wi;
      i_valid   = op.ld | op.st;
      i_ctrlMEM = '0;
      i_ctrlMEM.memRead  = op.ld;
      i_ctrlMEM.memWrite = op.st;
      i_ctrlMEM.size     = op.size;
      i_memAddr = op.addr; i_writeData = op.data;
      i_memBusy = op.busy; i_fence = op.fence;
      @(negedge i_clk);
      n = sq.size();
      blocked = m_fence || (op.fence && n > 0);
      hit = 1'b0;
      foreach (sq[i]) if (sq[i].addr[31:2] == op.addr[31:2]) hit = 1'b1;
      ld_go   = op.ld && !hit && !blocked;
      drn     = (n > 0) && !ld_go && !op.busy;
      e_stall = blocked || (op.ld && hit) || (op.st && n == DEPTH && !drn);
      e_ctrl = '0; e_addr = '0; e_data = '0;
      if (ld_go) begin
         e_ctrl.memRead = 1'b1; e_ctrl.size = op.size; e_addr = op.addr;
      end else if (drn) begin
         e_ctrl.memWrite = 1'b1; e_ctrl.size = sq[0].size; e_addr = sq[0].addr; e_data = sq[0].data;
      end
      chk("stall", 64'(o_stall), 64'(e_stall));
      chk("count", 64'(o_count), 64'(n));
      chk("ctrl",  64'(o_ctrlMEM), 64'(e_ctrl));
      chk("addr",  64'(o_memAddr), 64'(e_addr));
      chk("wdata", 64'(o_writeData), 64'(e_data));
      // Data memory driven by the DUT port
      l_rdata = '0;
      if (o_ctrlMEM.memWrite) begin
         wi = int'(o_memAddr[31:2]);
         dut_mem[wi] = merge(dut_mem.exists(wi) ? dut_mem[wi] : 32'h0, o_memAddr, o_writeData, o_ctrlMEM.size);
      end else if (o_ctrlMEM.memRead) begin
         wi = int'(o_memAddr[31:2]);
         l_rdata = dut_mem.exists(wi) ? dut_mem[wi] : 32'h0;
      end
      l_stall = o_stall; l_we = o_ctrlMEM.memWrite; l_addr = o_memAddr; l_cnt = int'(o_count);
      // Model update
      if (drn) begin
         wi = int'(sq[0].addr[31:2]);
         ref_mem[wi] = merge(ref_mem.exists(wi) ? ref_mem[wi] : 32'h0, sq[0].addr, sq[0].data, sq[0].size);
         void'(sq.pop_front());
      end
      if (op.st && !e_stall) sq.push_back('{addr: op.addr, data: op.data & bmask(op.size), size: op.size});
      m_fence = blocked && sq.size() > 0;
      @(posedge i_clk);
      #1;
   endtask

   op_t  idle, rop;
   vec_t vt[$];

   initial begin
      idle = mk(0, 0, 0, 0, 32'h0, 32'h0, 2'd0);

      // Reset state
      #1;
      chk("rst_count", 64'(o_count), 64'd0);
      chk("rst_stall", 64'(o_stall), 64'd0);
      chk("rst_ctrl",  64'(o_ctrlMEM), 64'd0);
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;

      // Directed table: single store, full-with-busy, full-with-pop, fence with 3 entries
      vt.push_back('{mk(0,1,0,0,32'h100,32'h11223344,2'd2), 0,0,32'h0,   0});
      vt.push_back('{idle,                                  0,1,32'h100, 1});
      vt.push_back('{idle,                                  0,0,32'h0,   0});
      vt.push_back('{mk(0,1,1,0,32'h10,32'hA0,2'd2),        0,0,32'h0,   0});
      vt.push_back('{mk(0,1,1,0,32'h14,32'hA1,2'd2),        0,0,32'h0,   1});
      vt.push_back('{mk(0,1,1,0,32'h18,32'hA2,2'd2),        0,0,32'h0,   2});
      vt.push_back('{mk(0,1,1,0,32'h1C,32'hA3,2'd2),        0,0,32'h0,   3});
      vt.push_back('{mk(0,1,1,0,32'h20,32'hA4,2'd2),        1,0,32'h0,   4});
      vt.push_back('{mk(0,1,0,0,32'h20,32'hA4,2'd2),        0,1,32'h10,  4});
      vt.push_back('{idle,                                  0,1,32'h14,  4});
      vt.push_back('{idle,                                  0,1,32'h18,  3});
      vt.push_back('{idle,                                  0,1,32'h1C,  2});
      vt.push_back('{idle,                                  0,1,32'h20,  1});
      vt.push_back('{idle,                                  0,0,32'h0,   0});
      vt.push_back('{mk(0,1,1,0,32'h30,32'hB0,2'd2),        0,0,32'h0,   0});
      vt.push_back('{mk(0,1,1,0,32'h34,32'hB1,2'd2),        0,0,32'h0,   1});
      vt.push_back('{mk(0,1,1,0,32'h38,32'hB2,2'd2),        0,0,32'h0,   2});
      vt.push_back('{mk(0,0,0,1,32'h0,32'h0,2'd0),          1,1,32'h30,  3});
      vt.push_back('{mk(0,0,0,1,32'h0,32'h0,2'd0),          1,1,32'h34,  2});
      vt.push_back('{mk(0,0,0,1,32'h0,32'h0,2'd0),          1,1,32'h38,  1});
      vt.push_back('{mk(0,0,0,1,32'h0,32'h0,2'd0),          0,0,32'h0,   0});
      vt.push_back('{idle,                                  0,0,32'h0,   0});
      foreach (vt[i]) begin
         step(vt[i].op);
         chk($sformatf("vec%0d_stall", i), 64'(l_stall), 64'(vt[i].e_stall));
         chk($sformatf("vec%0d_we", i),    64'(l_we),    64'(vt[i].e_we));
         if (vt[i].e_we) chk($sformatf("vec%0d_addr", i), 64'(l_addr), 64'(vt[i].e_addr));
         chk($sformatf("vec%0d_cnt", i),   64'(l_cnt),   64'(vt[i].e_cnt));
      end

      // Byte store then conflicting word load: stalls until drained, then sees the byte
      dut_mem[32'h200 >> 2] = 32'h55667788;
      ref_mem[32'h200 >> 2] = 32'h55667788;
      step(mk(0,1,0,0,32'h203,32'h123456AA,2'd0));
      step(mk(1,0,1,0,32'h200,32'h0,2'd2));
      chk("raw_stall_busy", 64'(l_stall), 64'd1);
      step(mk(1,0,0,0,32'h200,32'h0,2'd2));
      chk("raw_stall_drain", 64'(l_stall), 64'd1);
      chk("raw_drain_we", 64'(l_we), 64'd1);
      step(mk(1,0,0,0,32'h200,32'h0,2'd2));
      chk("raw_issue", 64'(l_stall), 64'd0);
      chk("raw_rdata", 64'(l_rdata), 64'h00000000AA667788);

      // Reset with two stores pending: immediate clear, nothing written afterwards
      step(mk(0,1,1,0,32'h40,32'hC0,2'd2));
      step(mk(0,1,1,0,32'h44,32'hC1,2'd2));
      i_valid = 1'b0; i_ctrlMEM = '0; i_memBusy = 1'b1;
      #2;
      i_reset_n = 1'b0;
      #1;
      chk("arst_count", 64'(o_count), 64'd0);
      chk("arst_stall", 64'(o_stall), 64'd0);
      chk("arst_ctrl",  64'(o_ctrlMEM), 64'd0);
      sq.delete();
      m_fence = 1'b0;
      @(posedge i_clk); #1;
      i_reset_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(idle);
         chk("post_rst_no_write", 64'(l_we), 64'd0);
      end

      // Random traffic over a small address window to force conflicts and fills
      for (int i = 0; i < 600; i++) begin
         int r;
         logic [1:0] sz;
         logic [31:0] a;
         r  = $urandom_range(0, 9);
         sz = 2'($urandom_range(0, 2));
         a  = 32'h300 + 32'($urandom_range(0, 7) << 2);
         if (sz == 2'd0)      a[1:0] = 2'($urandom_range(0, 3));
         else if (sz == 2'd1) a[1]   = 1'($urandom_range(0, 1));
         rop = mk(r >= 4 && r <= 6, r <= 3, $urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0,
                  a, $urandom, sz);
         step(rop);
      end
      for (int i = 0; i < 8; i++) step(idle);
      chk("final_empty", 64'(o_count), 64'd0);
      foreach (ref_mem[k])
         chk($sformatf("mem_%0h", k), 64'(dut_mem.exists(k) ? dut_mem[k] : 32'h0), 64'(ref_mem[k]));

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_store_buffer.md
MEM_STORE_BUFFER -- requirements
Module: mem_store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of store entries; legal values are powers of two from 2 to 16.
REQ-002 SHALL have port i_clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port i_valid, input, 1 bit: the MEM-stage operation is valid this cycle.
REQ-005 SHALL have port i_memAddr, input, 32 bits: byte address of the MEM-stage access.
REQ-006 SHALL have port i_writeData, input, 32 bits: store data; only the low bytes selected by size are used.
REQ-007 SHALL have port i_ctrlMEM, input, mem_ctrl_t: carries memRead, memWrite, size and sign.
REQ-008 SHALL have port i_memBusy, input, 1 bit: the memory port is taken by another master, so no drain may happen this cycle.
REQ-009 SHALL have port i_fence, input, 1 bit: drain the buffer completely before any further access.
REQ-010 SHALL have port o_memAddr, output, 32 bits: address presented to the data memory.
REQ-011 SHALL have port o_writeData, output, 32 bits: data presented to the data memory.
REQ-012 SHALL have port o_ctrlMEM, output, mem_ctrl_t: control presented to the data memory.
REQ-013 SHALL have port o_stall, output, 1 bit: hold the pipeline at and before MEM.
REQ-014 SHALL have port o_count, output, $clog2(DEPTH)+1 bits: current number of valid entries.

Function
REQ-015 SHALL accept a store (i_valid & memWrite & !o_stall) into the tail entry as {addr, data, size} at the rising edge; the write reaches memory 1 or more cycles later.
REQ-016 SHALL drive o_* combinationally from the head entry with memWrite=1 and memRead=0 when count>0, no load is issued this cycle, and i_memBusy=0; the head is popped at that rising edge.
REQ-017 SHALL pass a load (i_valid & memRead) straight to o_* with memWrite=0, taking priority over drain, unless it conflicts.
REQ-018 SHALL treat a load as conflicting when any valid entry has addr[31:2] equal to the load's addr[31:2]; the load is then stalled and not issued, and draining continues.
REQ-019 SHALL drive o_ctrlMEM to all zeros when the port is idle.
REQ-020 SHALL assert o_stall on a store when count==DEPTH and no pop occurs this cycle; when full with a simultaneous pop, the store is accepted without stall.
REQ-021 SHALL wrap head and tail pointers modulo DEPTH, with count = pushes - pops and never outside 0..DEPTH.
REQ-022 SHALL implement a state machine with states RUN and FENCE: RUN goes to FENCE when i_fence=1 and count>0; FENCE goes to RUN when count reaches 0; o_stall=1 throughout FENCE; i_fence with count==0 causes no stall.
REQ-023 SHALL NOT accept stores or issue loads while in FENCE.
REQ-024 SHALL preserve program order of stores, so that two stores to the same word reach memory oldest first.

Reset
REQ-025 SHALL, on i_reset_n low, immediately clear all entry valid bits, head, tail and count to 0, and set state to RUN; o_stall=0 and o_ctrlMEM=0.
REQ-026 SHALL discard in-flight stores on reset; no memory write is issued in the cycle in which reset deasserts.

Structure
REQ-027 SHALL reuse mem_ctrl_t and define sb_state_t {RUN, FENCE} in the shared core package.
REQ-028 SHALL contain one sub-module, mem_sb_cam, which holds the entry array and produces the word-address conflict vector for REQ-018.

Verification
REQ-029 SHALL cover: sw 0x11223344 to 0x100 then idle -> memory write to 0x100 one cycle later; count goes 1 then 0.
REQ-030 SHALL cover: i_memBusy=1 while 5 stores issue with DEPTH=4 -> the 5th store has o_stall=1 and count=4; on release the writes drain in order.
REQ-031 SHALL cover: sb 0xAA to 0x203 then lw 0x200 -> the load stalls until the drain completes and returns a word with byte3=0xAA.
REQ-032 SHALL cover: a store when count=4 while a drain pops in the same cycle -> no stall and count remains 4.
REQ-033 SHALL cover: i_fence with 3 entries -> o_stall=1 for 3 cycles, then state returns to RUN and count=0.
REQ-034 SHALL cover: i_reset_n pulsed low with 2 entries -> count=0 immediately and no write is issued afterwards.
